// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter/sequencer in front of a shared NUM_REQ:1 data mux.
//   One requester owns the output channel for a whole packet; the grant is
//   released after the beat flagged last is accepted downstream. The
//   requester served most recently becomes lowest priority.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester beat valid            [NUM_REQ]
//   req_data   packed beats, req i at [i*DATA_W +: DATA_W]
//   req_last   per-requester last-beat flag        [NUM_REQ]
//   req_ready  per-requester accept (owner only)   [NUM_REQ]
//   out_valid  muxed beat valid
//   out_data   muxed beat data                     [DATA_W]
//   out_last   muxed last flag
//   out_ready  downstream accept
//   grant_id   index of the current owner          [ID_W]
//   busy       high while a grant is held
//   timeout    one-cycle pulse after a forced release
//
// Optional build macro: RR_MUX_ARB_TIMEOUT_EN
//   Adds a stall watchdog that force-releases an owner after TIMEOUT_CYCLES
//   consecutive grant cycles without a transfer. Without it the grant is
//   held until the last beat and timeout is tied low.

module rr_mux_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout
);

  // Elaboration-time parameter sanity checks.
  if ((1 << ID_W) < NUM_REQ) begin : g_bad_id_w
    $error("rr_mux_arbiter: ID_W too narrow for NUM_REQ");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rr_mux_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_id_q;
  logic [ID_W-1:0] ptr_q;

  logic            found;
  logic [ID_W-1:0] winner;
  logic            sel_valid;
  logic            sel_last;
  logic [DATA_W-1:0] sel_data;
  logic            xfer;
  logic            stall_hit;

  // Round-robin search: first valid index above ptr, then wrap to the
  // indices at or below ptr. Two linear passes avoid any modulo hardware
  // and work for non-power-of-2 NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) > ptr_q)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) <= ptr_q)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end

  // Datapath mux selected by the registered owner index.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer = (state_q == GRANT) && sel_valid && out_ready;

`ifdef RR_MUX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q;

  assign stall_hit = (state_q == GRANT) && !xfer &&
                     (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cleared while idle (so every new grant starts at zero) and on each
  // accepted beat; counts only stalled grant cycles.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE || xfer) begin
      stall_d = '0;
    end else begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= stall_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign stall_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if ((xfer && sel_last) || stall_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner index and priority pointer are loaded together at grant time, so
  // the just-granted requester becomes lowest priority for the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id_q <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
    end else if (state_q == IDLE && found) begin
      grant_id_q <= winner;
      ptr_q      <= winner;
    end
  end

  // Output logic.
  always_comb begin
    busy      = (state_q == GRANT);
    out_valid = busy && sel_valid;
    out_last  = busy && sel_last;
    out_data  = sel_data;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy && out_ready && (ID_W'(i) == grant_id_q);
    end
  end

  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  rr_mux_arbiter #(
    .NUM_REQ(N), .DATA_W(W), .ID_W(IDW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner/pointer/stall tracked as plain integers.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_stall;
  bit m_to;
  bit m_xfer;
  logic [W-1:0] s_data;

  function automatic logic [W-1:0] beat_of(input int i);
    logic [N*W-1:0] d;
    d = req_data;
    return d[i*W +: W];
  endfunction

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_ptr = N - 1; m_stall = 0; m_to = 0; m_xfer = 0;
  endtask

  task automatic model_check(input string tag);
    bit           ov;
    logic [N-1:0] rr;
    ov = m_busy && req_valid[m_owner];
    rr = (m_busy && out_ready) ? N'(1 << m_owner) : '0;
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(m_owner));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rr));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    if (ov) begin
      chk({tag, ".out_data"}, 32'(out_data), 32'(beat_of(m_owner)));
      chk({tag, ".out_last"}, 32'(out_last), 32'(req_last[m_owner]));
    end
  endtask

  task automatic model_advance();
    m_xfer = m_busy && req_valid[m_owner] && out_ready;
    m_to   = 0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req_valid[c]) begin
          m_owner = c; m_ptr = c; m_busy = 1; m_stall = 0;
          break;
        end
      end
    end else if (m_xfer) begin
      m_stall = 0;
      if (req_last[m_owner]) m_busy = 0;
    end else begin
`ifdef RR_MUX_ARB_TIMEOUT_EN
      if (m_stall == TO - 1) begin
        m_busy = 0;
        m_to   = 1;
      end
`endif
      m_stall++;
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    model_check(tag);
    s_data = out_data;
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]   rv;
    logic [IDW-1:0] gid;
    logic           bsy;
    logic           ov;
    logic [N-1:0]   rr;
    logic [W-1:0]   od;
  } vec_t;

  vec_t vecs[10];
  logic [W-1:0] beats[$];
  logic [W-1:0] exp_beats[3];
  int pulses;
  int b;
  int pi;
  logic ordy_pat[4];

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
    m_reset();

    // Reset state with all requesters valid.
    req_valid = '1; req_last = '1; out_ready = 1'b1;
    req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_check("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All four requesters stream single-beat packets.
    vecs[0] = '{4'hF, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00};
    vecs[1] = '{4'hF, 2'd0, 1'b1, 1'b1, 4'b0001, 8'hC0};
    vecs[2] = '{4'hF, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h00};
    vecs[3] = '{4'hF, 2'd1, 1'b1, 1'b1, 4'b0010, 8'hC1};
    vecs[4] = '{4'hF, 2'd1, 1'b0, 1'b0, 4'b0000, 8'h00};
    vecs[5] = '{4'hF, 2'd2, 1'b1, 1'b1, 4'b0100, 8'hC2};
    vecs[6] = '{4'hF, 2'd2, 1'b0, 1'b0, 4'b0000, 8'h00};
    vecs[7] = '{4'hF, 2'd3, 1'b1, 1'b1, 4'b1000, 8'hC3};
    vecs[8] = '{4'hF, 2'd3, 1'b0, 1'b0, 4'b0000, 8'h00};
    vecs[9] = '{4'hF, 2'd0, 1'b1, 1'b1, 4'b0001, 8'hC0};
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].rv;
      @(negedge clk);
      chk("tbl.grant_id", 32'(grant_id), 32'(vecs[i].gid));
      chk("tbl.busy", 32'(busy), 32'(vecs[i].bsy));
      chk("tbl.out_valid", 32'(out_valid), 32'(vecs[i].ov));
      chk("tbl.req_ready", 32'(req_ready), 32'(vecs[i].rr));
      if (vecs[i].ov) chk("tbl.out_data", 32'(out_data), 32'(vecs[i].od));
      @(posedge clk);
      model_advance();
      #1;
    end

    // Three-beat packet from requester 2 while requester 1 waits.
    do_reset();
    exp_beats[0] = 8'hA1; exp_beats[1] = 8'hA2; exp_beats[2] = 8'hA3;
    ordy_pat[0] = 1'b1; ordy_pat[1] = 1'b0; ordy_pat[2] = 1'b1; ordy_pat[3] = 1'b1;
    req_valid = 4'b0100; req_last = '0; out_ready = 1'b1;
    req_data = {8'h3F, 8'hA1, 8'h1E, 8'h0D};
    b = 0; pi = 0;
    beats.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      req_valid[2] = (b < 3);
      req_data[2*W +: W] = exp_beats[(b < 3) ? b : 2];
      req_last[2] = (b == 2);
      req_last[1] = 1'b1;
      if (cyc > 0) req_valid[1] = 1'b1;
      out_ready = (m_busy && m_owner == 2) ? ordy_pat[(pi < 4) ? pi : 3] : 1'b1;
      step("pkt3");
      if (m_xfer && m_owner == 2 && b < 3) begin
        beats.push_back(s_data);
        b++;
      end
      if (m_busy && m_owner == 2) pi++;
    end
    chk("pkt3.beat_count", 32'(beats.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("pkt3.beat_order", 32'((i < beats.size()) ? beats[i] : 8'hXX), 32'(exp_beats[i]));
    chk("pkt3.next_owner", 32'(grant_id), 32'd1);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    req_valid = 4'b0010; req_last = '0; out_ready = 1'b1;
    req_data = {8'h44, 8'h33, 8'h55, 8'h11};
    step("midrst");
    step("midrst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.grant_id", 32'(grant_id), 32'd0);
    chk("midrst.req_ready", 32'(req_ready), 32'd0);
    m_reset();
    req_valid = '1; req_last = '1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("restart");
    step("restart");
    chk("restart.first_owner", 32'(grant_id), 32'd0);

    // Stalled owner: watchdog release when built in, indefinite hold otherwise.
    do_reset();
    req_valid = 4'b0110; req_last = '0; out_ready = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      step("stall");
      if (timeout === 1'b1) pulses++;
    end
`ifdef RR_MUX_ARB_TIMEOUT_EN
    chk("stall.timeout_pulses", 32'(pulses), 32'd1);
    chk("stall.next_owner", 32'(grant_id), 32'd2);
`else
    chk("stall.timeout_pulses", 32'(pulses), 32'd0);
    chk("stall.held_owner", 32'(grant_id), 32'd1);
`endif

    // Only requester 3: search wraps all the way round to itself.
    do_reset();
    req_valid = 4'b1000; req_last = 4'b1000; out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step("solo3");
      if (m_busy) chk("solo3.grant_id", 32'(grant_id), 32'd3);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom);
      req_data  = {$urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
